ibex_mem_responder: RTL

Memory-side responder for the Ibex req/gnt/rvalid instruction and data bus. A core's `instr_*` or `data_*` port connects directly to it. It holds a word-addressed memory, grants requests after a configurable delay, and returns responses in order after a fixed latency. Used as the instruction/data memory for single-core and dual-core (miter) formal and simulation harnesses. Two instances sharing identical inputs must respond identically.

---
 rtl/ibex_mem_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ibex_mem_responder.sv
// rtl/ibex_mem_responder.sv - word-addressed req/gnt/rvalid memory responder with delayed grant and fixed-latency in-order responses
// Optional out-of-range error responses: define IBEX_MEM_RESP_ERR_EN.
module ibex_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);
  localparam int unsigned AW     = $clog2(MemWords);
  localparam logic [1:0]  GntDly = 2'(GntDelay);
  localparam logic [2:0]  MaxOut = 3'(MaxOutstanding);

  logic [31:0] mem [MemWords];

  logic [1:0]             wcnt_q, wcnt_d;
  logic [2:0]             outstanding_q, outstanding_d;
  logic [RespLatency-1:0] pvalid_q, pvalid_d;
  logic [RespLatency-1:0] perr_q, perr_d;
  logic [31:0]            pdata_q [RespLatency];
  logic [31:0]            pdata_d [RespLatency];
  logic                   pend_q, pend_d;
  logic                   prot_err_q, prot_err_d;
  logic                   snap_we_q, snap_we_d;
  logic [3:0]             snap_be_q, snap_be_d;
  logic [31:0]            snap_addr_q, snap_addr_d;
  logic [31:0]            snap_wdata_q, snap_wdata_d;

  logic          gnt;
  logic          hit;
  logic [AW-1:0] widx;
  logic [31:0]   resp_data;
  logic          resp_err;

  assign gnt = req_i && (wcnt_q == GntDly) && (outstanding_q < MaxOut);

  // Without the error feature the index simply wraps, aliasing into the array.
  always_comb begin
    widx = AW'((addr_i - BaseAddr) >> 2);
`ifdef IBEX_MEM_RESP_ERR_EN
    hit  = ((addr_i - BaseAddr) >> 2) < 32'(MemWords);
`else
    hit  = 1'b1;
`endif
    resp_err  = !hit;
    resp_data = (we_i || !hit) ? 32'h0 : mem[widx];
  end

  always_ff @(posedge clk_i) begin
    if (gnt && we_i && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem[widx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (!req_i || gnt)        wcnt_d = 2'd0;
    else if (wcnt_q != GntDly) wcnt_d = wcnt_q + 2'd1;

    outstanding_d = outstanding_q + {2'b00, gnt} - {2'b00, pvalid_q[RespLatency-1]};

    pvalid_d   = pvalid_q;
    perr_d     = perr_q;
    pdata_d    = pdata_q;
    pvalid_d[0] = gnt;
    perr_d[0]   = gnt && resp_err;
    pdata_d[0]  = gnt ? resp_data : 32'h0;
    for (int i = 1; i < RespLatency; i++) begin
      pvalid_d[i] = pvalid_q[i-1];
      perr_d[i]   = perr_q[i-1];
      pdata_d[i]  = pdata_q[i-1];
    end

    // A request left waiting last cycle must reappear unchanged this cycle.
    pend_d       = req_i && !gnt;
    snap_we_d    = we_i;
    snap_be_d    = be_i;
    snap_addr_d  = addr_i;
    snap_wdata_d = wdata_i;
    prot_err_d   = prot_err_q ||
                   (pend_q && (!req_i || (we_i != snap_we_q) || (be_i != snap_be_q) ||
                               (addr_i != snap_addr_q) || (wdata_i != snap_wdata_q)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q        <= 2'd0;
      outstanding_q <= 3'd0;
      pvalid_q      <= '0;
      perr_q        <= '0;
      for (int i = 0; i < RespLatency; i++) pdata_q[i] <= 32'h0;
      pend_q        <= 1'b0;
      prot_err_q    <= 1'b0;
      snap_we_q     <= 1'b0;
      snap_be_q     <= 4'h0;
      snap_addr_q   <= 32'h0;
      snap_wdata_q  <= 32'h0;
    end else begin
      wcnt_q        <= wcnt_d;
      outstanding_q <= outstanding_d;
      pvalid_q      <= pvalid_d;
      perr_q        <= perr_d;
      pdata_q       <= pdata_d;
      pend_q        <= pend_d;
      prot_err_q    <= prot_err_d;
      snap_we_q     <= snap_we_d;
      snap_be_q     <= snap_be_d;
      snap_addr_q   <= snap_addr_d;
      snap_wdata_q  <= snap_wdata_d;
    end
  end

  assign gnt_o          = gnt;
  assign rvalid_o       = pvalid_q[RespLatency-1];
  assign rdata_o        = pdata_q[RespLatency-1];
  assign err_o          = perr_q[RespLatency-1];
  assign outstanding_o  = outstanding_q;
  assign protocol_err_o = prot_err_q;
endmodule
